// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the MIPS run controller: state encoding, default timings
// and the run-mode selection helper.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_DELAY     = 3'd1,
      ST_RUN       = 3'd2,
      ST_STEP_IDLE = 3'd3,
      ST_STEP_FIRE = 3'd4,
      ST_HALT      = 3'd5
   } state_e;

   localparam int DEF_RST_HOLD    = 5;
   localparam int DEF_START_DELAY = 100;
   localparam int TIMER_W         = 32;

   function automatic state_e mode_state(input logic step_mode);
      return step_mode ? ST_STEP_IDLE : ST_RUN;
   endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Control/status bundle between the run controller and its driver (board or bench).
interface mips_run_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             restart;
   logic             step_mode;
   logic             step_req;
   logic             halt_req;
   logic             core_rst;
   logic             core_clk_en;
   logic [CNT_W-1:0] cycle_count;
   logic             done;
   logic [2:0]       state_o;

   modport master (
      output restart, step_mode, step_req, halt_req,
      input  core_rst, core_clk_en, cycle_count, done, state_o
   );

   modport slave (
      input  restart, step_mode, step_req, halt_req,
      output core_rst, core_clk_en, cycle_count, done, state_o
   );
endinterface

// File: rtl/mips_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = sat_inc(cnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS core: reset hold, start-up delay, free-run / single-step,
// halt on request or cycle budget. All outputs are registered decodes of the next state.
module mips_run_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int RST_HOLD    = DEF_RST_HOLD,
   parameter int START_DELAY = DEF_START_DELAY,
   parameter int CNT_W       = 32,
   parameter int MAX_CYCLES  = 0
) (
   input  logic            clk,
   input  logic            rst,
   mips_run_ctrl_if.slave  bus
);
   localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(RST_HOLD - 1);
   localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(START_DELAY - 1);
   localparam logic [CNT_W-1:0]   BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam bit                 BUDGET_ON   = (MAX_CYCLES != 0);
   localparam bit                 SKIP_DELAY  = (START_DELAY == 0);

   state_e             state_q, state_d;
   logic               step_prev_q;
   logic               core_rst_q, core_rst_d;
   logic               clk_en_q, clk_en_d;
   logic               done_q, done_d;
   logic [TIMER_W-1:0] timer_cnt;
   logic [CNT_W-1:0]   cycle_cnt;
   logic               step_edge, budget_hit, timer_clr, timer_en;

   assign step_edge  = bus.step_req & ~step_prev_q;
   assign budget_hit = BUDGET_ON && (cycle_cnt == BUDGET_LAST);

   // Priority: restart, halt_req, budget, step_mode change, step edge.
   always_comb begin
      state_d = state_q;
      if (bus.restart) begin
         state_d = ST_HOLD;
      end else begin
         case (state_q)
            ST_HOLD:
               if (timer_cnt == HOLD_LAST)
                  state_d = SKIP_DELAY ? mode_state(bus.step_mode) : ST_DELAY;
            ST_DELAY:
               if (bus.halt_req)                state_d = ST_HALT;
               else if (timer_cnt == DELAY_LAST) state_d = mode_state(bus.step_mode);
            ST_RUN:
               if (bus.halt_req || budget_hit) state_d = ST_HALT;
               else if (bus.step_mode)         state_d = ST_STEP_IDLE;
            ST_STEP_IDLE:
               if (bus.halt_req)        state_d = ST_HALT;
               else if (!bus.step_mode) state_d = ST_RUN;
               else if (step_edge)      state_d = ST_STEP_FIRE;
            ST_STEP_FIRE:
               if (bus.halt_req || budget_hit) state_d = ST_HALT;
               else                            state_d = mode_state(bus.step_mode);
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HOLD;
         endcase
      end

      core_rst_d = (state_d == ST_HOLD);
      clk_en_d   = (state_d == ST_RUN) || (state_d == ST_STEP_FIRE);
      done_d     = (state_d == ST_HALT);
   end

   // The hold/delay timer restarts from zero on every state change.
   assign timer_clr = bus.restart || (state_d != state_q);
   assign timer_en  = (state_q == ST_HOLD) || (state_q == ST_DELAY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HOLD;
         step_prev_q <= 1'b0;
         core_rst_q  <= 1'b1;
         clk_en_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_prev_q <= bus.step_req;
         core_rst_q  <= core_rst_d;
         clk_en_q    <= clk_en_d;
         done_q      <= done_d;
      end
   end

   sat_counter #(.W(TIMER_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (timer_clr),
      .en_i  (timer_en),
      .cnt_o (timer_cnt)
   );

   sat_counter #(.W(CNT_W)) u_cycles (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.restart),
      .en_i  (clk_en_q),
      .cnt_o (cycle_cnt)
   );

   assign bus.core_rst    = core_rst_q;
   assign bus.core_clk_en = clk_en_q;
   assign bus.cycle_count = cycle_cnt;
   assign bus.done        = done_q;
   assign bus.state_o     = state_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench: three controller configurations share one stimulus stream and are
// compared every cycle against a countdown-based reference model.
module tb_mips_run_ctrl;
   import mips_ctrl_pkg::*;

   localparam int ND = 3;

   typedef struct {
      int     dut;
      state_e st;
      bit     crst;
      bit     en;
      bit     done;
      longint cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic restart = 1'b0, step_mode = 1'b0, step_req = 1'b0, halt_req = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mips_run_ctrl_if #(.CNT_W(32)) if0 ();
   mips_run_ctrl_if #(.CNT_W(32)) if1 ();
   mips_run_ctrl_if #(.CNT_W(4))  if2 ();

   assign if0.restart = restart;  assign if0.step_mode = step_mode;
   assign if0.step_req = step_req; assign if0.halt_req = halt_req;
   assign if1.restart = restart;  assign if1.step_mode = step_mode;
   assign if1.step_req = step_req; assign if1.halt_req = halt_req;
   assign if2.restart = restart;  assign if2.step_mode = step_mode;
   assign if2.step_req = step_req; assign if2.halt_req = halt_req;

   mips_run_ctrl #(.RST_HOLD(3), .START_DELAY(4), .CNT_W(32), .MAX_CYCLES(0))
      dut0 (.clk(clk), .rst(rst), .bus(if0));
   mips_run_ctrl #(.RST_HOLD(3), .START_DELAY(4), .CNT_W(32), .MAX_CYCLES(10))
      dut1 (.clk(clk), .rst(rst), .bus(if1));
   mips_run_ctrl #(.RST_HOLD(DEF_RST_HOLD), .START_DELAY(0), .CNT_W(4), .MAX_CYCLES(0))
      dut2 (.clk(clk), .rst(rst), .bus(if2));

   logic [2:0]  a_st   [ND];
   logic        a_crst [ND];
   logic        a_en   [ND];
   logic        a_done [ND];
   logic [31:0] a_cnt  [ND];

   assign a_st[0] = if0.state_o;  assign a_crst[0] = if0.core_rst; assign a_en[0] = if0.core_clk_en;
   assign a_done[0] = if0.done;   assign a_cnt[0] = if0.cycle_count;
   assign a_st[1] = if1.state_o;  assign a_crst[1] = if1.core_rst; assign a_en[1] = if1.core_clk_en;
   assign a_done[1] = if1.done;   assign a_cnt[1] = if1.cycle_count;
   assign a_st[2] = if2.state_o;  assign a_crst[2] = if2.core_rst; assign a_en[2] = if2.core_clk_en;
   assign a_done[2] = if2.done;   assign a_cnt[2] = {28'd0, if2.cycle_count};

   function automatic int p_hold(input int d);
      return (d == 2) ? DEF_RST_HOLD : 3;
   endfunction
   function automatic int p_delay(input int d);
      return (d == 2) ? 0 : 4;
   endfunction
   function automatic longint p_max(input int d);
      return (d == 1) ? 10 : 0;
   endfunction
   function automatic longint p_top(input int d);
      return (d == 2) ? 64'd15 : 64'hFFFF_FFFF;
   endfunction

   // Reference model: remaining-cycle countdowns plus a plain enabled-cycle tally.
   state_e m_st    [ND];
   int     m_hold  [ND];
   int     m_delay [ND];
   longint m_cnt   [ND];
   bit     m_prev  [ND];

   task automatic model_reset(input int d);
      m_st[d]   = ST_HOLD;
      m_hold[d] = p_hold(d);
      m_cnt[d]  = 0;
      m_prev[d] = 1'b0;
   endtask

   task automatic model_step(input int d);
      bit running, over, edg;
      if (rst) begin
         model_reset(d);
         return;
      end
      running = (m_st[d] == ST_RUN) || (m_st[d] == ST_STEP_FIRE);
      over    = (p_max(d) != 0) && (m_cnt[d] + 1 == p_max(d));
      edg     = step_req && !m_prev[d];
      m_prev[d] = step_req;
      if (restart) begin
         m_st[d]   = ST_HOLD;
         m_hold[d] = p_hold(d);
         m_cnt[d]  = 0;
         return;
      end
      if (running && m_cnt[d] < p_top(d)) m_cnt[d] = m_cnt[d] + 1;
      case (m_st[d])
         ST_HOLD: begin
            m_hold[d] = m_hold[d] - 1;
            if (m_hold[d] == 0) begin
               if (p_delay(d) == 0) m_st[d] = step_mode ? ST_STEP_IDLE : ST_RUN;
               else begin
                  m_st[d]    = ST_DELAY;
                  m_delay[d] = p_delay(d);
               end
            end
         end
         ST_DELAY: begin
            if (halt_req) m_st[d] = ST_HALT;
            else begin
               m_delay[d] = m_delay[d] - 1;
               if (m_delay[d] == 0) m_st[d] = step_mode ? ST_STEP_IDLE : ST_RUN;
            end
         end
         ST_RUN:
            if (halt_req || over) m_st[d] = ST_HALT;
            else if (step_mode)   m_st[d] = ST_STEP_IDLE;
         ST_STEP_IDLE:
            if (halt_req)        m_st[d] = ST_HALT;
            else if (!step_mode) m_st[d] = ST_RUN;
            else if (edg)        m_st[d] = ST_STEP_FIRE;
         ST_STEP_FIRE:
            if (halt_req || over) m_st[d] = ST_HALT;
            else                  m_st[d] = step_mode ? ST_STEP_IDLE : ST_RUN;
         default: m_st[d] = ST_HALT;
      endcase
   endtask

   task automatic push_exp(input int d);
      exp_t e;
      e.dut  = d;
      e.st   = m_st[d];
      e.crst = (m_st[d] == ST_HOLD);
      e.en   = (m_st[d] == ST_RUN) || (m_st[d] == ST_STEP_FIRE);
      e.done = (m_st[d] == ST_HALT);
      e.cnt  = m_cnt[d];
      sb.push_back(e);
   endtask

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit rs, input bit sm, input bit sr, input bit hr,
                        input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
         rst = r; restart = rs; step_mode = sm; step_req = sr; halt_req = hr;
         for (int d = 0; d < ND; d++) begin
            model_step(d);
            push_exp(d);
         end
      end
   endtask

   task automatic async_rst();
      @(posedge clk);
      #5;
      rst = 1'b1;
      #2;
      for (int d = 0; d < ND; d++) begin
         check($sformatf("d%0d.async_core_rst", d), a_crst[d], 1);
         check($sformatf("d%0d.async_clk_en", d), a_en[d], 0);
         check($sformatf("d%0d.async_state", d), a_st[d], ST_HOLD);
         check($sformatf("d%0d.async_count", d), a_cnt[d], 0);
         model_reset(d);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("d%0d.state", e.dut), a_st[e.dut], e.st);
            check($sformatf("d%0d.core_rst", e.dut), a_crst[e.dut], e.crst);
            check($sformatf("d%0d.clk_en", e.dut), a_en[e.dut], e.en);
            check($sformatf("d%0d.done", e.dut), a_done[e.dut], e.done);
            check($sformatf("d%0d.count", e.dut), a_cnt[e.dut], e.cnt);
         end
      end
   end

   initial begin : stimulus
      bit sm, sr;
      for (int d = 0; d < ND; d++) begin
         model_reset(d);
         push_exp(d);
      end
      // Power-up, then free run: budget halt on dut1, saturation on dut2.
      drive(1, 0, 0, 0, 0, 2);
      drive(0, 0, 0, 0, 0, 30);
      // Restart out of HALT into single-step; held request plus two pulses.
      drive(0, 1, 1, 0, 0);
      drive(0, 0, 1, 0, 0, 12);
      drive(0, 0, 1, 1, 0, 5);
      drive(0, 0, 1, 0, 0, 3);
      drive(0, 0, 1, 1, 0, 1);
      drive(0, 0, 1, 0, 0, 2);
      drive(0, 0, 1, 1, 0, 1);
      drive(0, 0, 1, 0, 0, 3);
      // Halt request and step edge in the same STEP_IDLE cycle.
      drive(0, 0, 1, 1, 1);
      drive(0, 0, 1, 0, 0, 4);
      // Restart into free run, then asynchronous reset mid-run.
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 15);
      async_rst();
      drive(1, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 20);
      // Randomised control traffic.
      sm = 1'b0;
      sr = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(19) == 0) sm = ~sm;
         if ($urandom_range(2) == 0)  sr = ~sr;
         drive(($urandom_range(199) == 0), ($urandom_range(79) == 0), sm, sr,
               ($urandom_range(39) == 0));
      end
      drive(0, 0, 0, 0, 0, 2);
      @(posedge clk);
      #3;
      check("scoreboard_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
